// File: rtl/uart_fifo_transceiver.sv
// rtl/uart_fifo_transceiver.sv - full-duplex 8N1 UART with a receive FIFO
module uart_fifo_transceiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_send,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       fifo_rd_en,
  output logic [7:0] fifo_dout,
  output logic       fifo_valid,
  output logic       fifo_empty,
  output logic       fifo_full
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic          tx_ready_q, tx_ready_d;

  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_ready_q, rx_ready_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    fifo_dout_q, fifo_dout_d;
  logic          fifo_valid_q, fifo_valid_d;

  logic rx_s, tx_cnt_end, rx_cnt_end, empty, full, wr_ok, rd_ok;

  assign rx_s       = rx_sync_q[1];
  assign tx_cnt_end = (tx_cnt_q == BIT_LAST);
  assign rx_cnt_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    uart_tx_d  = uart_tx_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_send) begin
          tx_state_d = S_START;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          uart_tx_d  = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
          uart_tx_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            uart_tx_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 1'b1;
            uart_tx_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_end) begin
          tx_state_d = S_IDLE;
          tx_ready_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Receiver samples mid-bit: half a bit after the falling edge, then every full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_prev_d  = rx_s;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_end) begin
          rx_state_d = S_IDLE;
          if (rx_s) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // The FIFO write happens in the cycle rx_ready is high, from the registered byte.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok = rx_ready_q && !full;
  assign rd_ok = fifo_rd_en && !empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    fifo_dout_d  = rd_ok ? mem_q[rd_ptr_q[AW-1:0]] : fifo_dout_q;
    fifo_valid_d = rd_ok;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      uart_tx_q    <= 1'b1;
      tx_ready_q   <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_dout_q  <= '0;
      fifo_valid_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      uart_tx_q    <= uart_tx_d;
      tx_ready_q   <= tx_ready_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_dout_q  <= fifo_dout_d;
      fifo_valid_q <= fifo_valid_d;
    end
  end

  assign uart_tx    = uart_tx_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign fifo_dout  = fifo_dout_q;
  assign fifo_valid = fifo_valid_q;
  assign fifo_empty = empty;
  assign fifo_full  = full;

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb/tb_uart_fifo_transceiver.sv - directed bench for uart_fifo_transceiver
module tb_uart_fifo_transceiver;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int B        = 16;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, uart_tx, uart_rx, rx_ready, fifo_valid, fifo_empty, fifo_full;
  logic [7:0] rx_data, fifo_dout;
  logic       fifo_rd_en = 1'b0;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;

  int vectors = 0;
  int errors  = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .rx_data(rx_data), .rx_ready(rx_ready),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one serial frame on rx_drv and counts rx_ready strobes; optionally
  // asserts fifo_rd_en in the strobe cycle and captures the read result.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input bit rd_on_strobe,
                             output int strobes, output logic got_valid, output logic [7:0] got_dout);
    logic [9:0] bits;
    bit armed;
    bits = {stop, d, 1'b0};
    armed = 0;
    strobes = 0;
    got_valid = 1'b0;
    got_dout = 8'h00;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < B; c++) begin
        if (k < 10) rx_drv = bits[k];
        else rx_drv = 1'b1;
        tick();
        if (armed) begin
          got_valid = fifo_valid;
          got_dout = fifo_dout;
          fifo_rd_en = 1'b0;
          armed = 0;
        end
        if (rx_ready) begin
          strobes++;
          if (rd_on_strobe) begin
            fifo_rd_en = 1'b1;
            armed = 1;
          end
        end
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx); end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    vectors++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    vectors++; if (fifo_dout !== 8'h00) begin errors++; $display("FAIL rst_fifo_dout: got %h want 00", fifo_dout); end
    vectors++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_valid: got %b want 0", fifo_valid); end
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_fifo_empty: got %b want 1", fifo_empty); end
    vectors++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_fifo_full: got %b want 0", fifo_full); end
    rst_n = 1'b1;
    loop_en = 1'b1;
    tick();
    tx_data = 8'hA5;
    tx_send = 1'b1;
    tick();
    tx_send = 1'b0;
    repeat (2 * B + 2) tick();
    vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_frame_uart_tx: got %b want 0", uart_tx); end
    vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_frame_tx_ready: got %b want 0", tx_ready); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_rst_uart_tx: got %b want 1", uart_tx); end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL async_rst_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL async_rst_empty: got %b want 1", fifo_empty); end
    vectors++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL async_rst_full: got %b want 0", fifo_full); end
    vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL async_rst_rx_ready: got %b want 0", rx_ready); end
    vectors++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", fifo_valid); end
    tick();
    rst_n = 1'b1;
    repeat (3 * B) tick();
    vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_rst_uart_tx: got %b want 1", uart_tx); end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_tx_ready: got %b want 1", tx_ready); end
    loop_en = 1'b0;
  endtask

  task automatic test_tx_framing();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    tick();
    tx_data = 8'hA5;
    tx_send = 1'b1;
    tick();
    tx_send = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < B; c++) begin
        vectors++; if (uart_tx !== frame[k]) begin errors++; $display("FAIL tx_bit%0d_cyc%0d: got %b want %b", k, c, uart_tx, frame[k]); end
        vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_busy_bit%0d_cyc%0d: got %b want 0", k, c, tx_ready); end
        if (k == 4 && c == 0) begin
          tx_data = 8'h00;
          tx_send = 1'b1;
        end else begin
          tx_send = 1'b0;
        end
        tick();
      end
    end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_stop: got %b want 1", tx_ready); end
    for (int c = 0; c < 2 * B; c++) begin
      vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after_ignored_send cyc%0d: got %b want 1", c, uart_tx); end
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp [9];
    int got;
    int n;
    exp = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h88, 8'h41, 8'h41, 8'h42};
    got = 0;
    loop_en = 1'b1;
    tick();
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          int t = 0;
          while (!tx_ready && t < 12 * B) begin
            tick();
            t++;
          end
          tx_data = exp[i];
          tx_send = 1'b1;
          tick();
          tx_send = 1'b0;
        end
      end
      begin
        int t = 0;
        logic prev = 1'b0;
        while (got < 9 && t < 120 * B) begin
          tick();
          t++;
          if (prev) begin
            vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL loop_strobe_width: got %b want 0", rx_ready); end
          end
          if (rx_ready) begin
            vectors++; if (rx_data !== exp[got]) begin errors++; $display("FAIL loop_rx_data%0d: got %h want %h", got, rx_data, exp[got]); end
            got++;
          end
          prev = rx_ready;
        end
      end
    join
    vectors++; if (got !== 9) begin errors++; $display("FAIL loop_strobe_count: got %0d want 9", got); end
    repeat (3) tick();
    n = 0;
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_valid) begin
        if (n < 9) begin
          vectors++; if (fifo_dout !== exp[n]) begin errors++; $display("FAIL loop_fifo_dout%0d: got %h want %h", n, fifo_dout, exp[n]); end
        end
        n++;
      end
    end
    fifo_rd_en = 1'b0;
    tick();
    vectors++; if (n !== 9) begin errors++; $display("FAIL loop_fifo_count: got %0d want 9", n); end
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL loop_fifo_empty: got %b want 1", fifo_empty); end
    loop_en = 1'b0;
    repeat (2 * B) tick();
  endtask

  task automatic test_rx_robustness();
    int s;
    logic gv;
    logic [7:0] gd;
    rx_drv = 1'b0;
    repeat (5) tick();
    rx_drv = 1'b1;
    s = 0;
    repeat (12 * B) begin
      tick();
      if (rx_ready) s++;
    end
    vectors++; if (s !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", s); end
    drive_frame(8'h3C, 1'b0, 0, s, gv, gd);
    vectors++; if (s !== 0) begin errors++; $display("FAIL frame_err_strobes: got %0d want 0", s); end
    vectors++; if (rx_data !== 8'h42) begin errors++; $display("FAIL frame_err_rx_data: got %h want 42", rx_data); end
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL frame_err_empty: got %b want 1", fifo_empty); end
    drive_frame(8'hC3, 1'b1, 0, s, gv, gd);
    vectors++; if (s !== 1) begin errors++; $display("FAIL good_frame_strobes: got %0d want 1", s); end
    vectors++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL good_frame_rx_data: got %h want c3", rx_data); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    vectors++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL good_frame_valid: got %b want 1", fifo_valid); end
    vectors++; if (fifo_dout !== 8'hC3) begin errors++; $display("FAIL good_frame_dout: got %h want c3", fifo_dout); end
    tick();
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL good_frame_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_fifo_full();
    int s;
    logic gv;
    logic [7:0] gd;
    for (int i = 0; i < 17; i++) begin
      drive_frame(8'(i), 1'b1, 0, s, gv, gd);
      vectors++; if (s !== 1) begin errors++; $display("FAIL full_strobe%0d: got %0d want 1", i, s); end
      if (i == 14) begin
        vectors++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_after15: got %b want 0", fifo_full); end
      end
      if (i >= 15) begin
        vectors++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_after%0d: got %b want 1", i + 1, fifo_full); end
      end
    end
    vectors++; if (rx_data !== 8'h10) begin errors++; $display("FAIL full_rx_data: got %h want 10", rx_data); end
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL full_read%0d_valid: got %b want 1", i, fifo_valid); end
      vectors++; if (fifo_dout !== 8'(i)) begin errors++; $display("FAIL full_read%0d_dout: got %h want %h", i, fifo_dout, 8'(i)); end
      if (i == 15) fifo_rd_en = 1'b0;
    end
    tick();
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %b want 1", fifo_empty); end
    vectors++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_drained_full: got %b want 0", fifo_full); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    vectors++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL empty_read_valid: got %b want 0", fifo_valid); end
  endtask

  task automatic test_simultaneous();
    int s;
    logic gv;
    logic [7:0] gd;
    logic [7:0] rest [3];
    rest = '{8'h22, 8'h33, 8'h44};
    drive_frame(8'h11, 1'b1, 0, s, gv, gd);
    drive_frame(8'h22, 1'b1, 0, s, gv, gd);
    drive_frame(8'h33, 1'b1, 0, s, gv, gd);
    drive_frame(8'h44, 1'b1, 1, s, gv, gd);
    vectors++; if (s !== 1) begin errors++; $display("FAIL simul_strobe: got %0d want 1", s); end
    vectors++; if (gv !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", gv); end
    vectors++; if (gd !== 8'h11) begin errors++; $display("FAIL simul_dout: got %h want 11", gd); end
    vectors++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b want 0", fifo_empty); end
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL simul_read%0d_valid: got %b want 1", i, fifo_valid); end
      vectors++; if (fifo_dout !== rest[i]) begin errors++; $display("FAIL simul_read%0d_dout: got %h want %h", i, fifo_dout, rest[i]); end
      if (i == 2) fifo_rd_en = 1'b0;
    end
    tick();
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_final_empty: got %b want 1", fifo_empty); end
    vectors++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL simul_final_valid: got %b want 0", fifo_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_framing();
    test_loopback();
    test_rx_robustness();
    test_fifo_full();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
